// File: rtl/reg_8bit_pkg.sv
// Shared constants for the Citrus datapath storage registers.
// Higher-level blocks pass DATA_W into reg_8bit rather than hard-coding widths.
package reg_8bit_pkg;

    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] DATA_RST_VAL = '0;

endpackage : reg_8bit_pkg

// File: rtl/reg_8bit_if.sv
// Bundles the write-enable/data/readback signals of one storage register.
// The producer drives the master side; the register sits on the slave side.
interface reg_8bit_if #(
    parameter int WIDTH = reg_8bit_pkg::DATA_W
);

    logic             we;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] q;

    modport master (
        output we,
        output data,
        input  q
    );

    modport slave (
        input  we,
        input  data,
        output q
    );

endinterface : reg_8bit_if

// File: rtl/reg_8bit.sv
// General-purpose storage register with synchronous load-enable and clear.
// Reset outranks write; o_data is the raw flop output with no bypass path.
module reg_8bit
    import reg_8bit_pkg::*;
#(
    parameter int               WIDTH   = DATA_W,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (i_we) begin
            data_d = i_data;
        end
    end

    // Reset is applied at the flop so it overrides any pending write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_data = data_q;

endmodule : reg_8bit

// File: tb/tb_reg_8bit.sv
// Directed self-checking bench for reg_8bit: reset, load, hold, clear,
// back-to-back writes, reset priority and edge-only updates.
module tb_reg_8bit;
    import reg_8bit_pkg::*;

    logic clk;
    logic srst;
    int   vectors;
    int   errors;
    time  last_pos;

    reg_8bit_if #(.WIDTH(DATA_W)) bus ();

    reg_8bit #(
        .WIDTH  (DATA_W),
        .RST_VAL(8'h00)
    ) dut (
        .i_clk  (clk),
        .i_reset(srst),
        .i_we   (bus.we),
        .i_data (bus.data),
        .o_data (bus.q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial last_pos = 0;
    always @(posedge clk) last_pos = $time;

    // o_data may only move in the time step of a rising edge.
    always @(bus.q) begin
        vectors = vectors + 1;
        if ($time != last_pos) begin
            errors = errors + 1;
            $display("FAIL edge_only: o_data changed to %h at %0t, last edge %0t", bus.q, $time, last_pos);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        srst = 1'b1; bus.we = 1'b1; bus.data = 'x;
        tick();
        vectors++;
        if (bus.q !== 8'h00) begin
            errors++;
            $display("FAIL reset_with_we: got %h expected %h", bus.q, 8'h00);
        end
        $display("reset: we=1 data=X -> o_data=%h", bus.q);
        srst = 1'b1; bus.we = 1'b0; bus.data = 8'h77;
        tick();
        vectors++;
        if (bus.q !== 8'h00) begin
            errors++;
            $display("FAIL reset_held: got %h expected %h", bus.q, 8'h00);
        end
        $display("reset held -> o_data=%h", bus.q);
    endtask

    task automatic test_load();
        srst = 1'b0; bus.we = 1'b1; bus.data = 8'hF0;
        #2;
        vectors++;
        if (bus.q !== 8'h00) begin
            errors++;
            $display("FAIL load_no_bypass: got %h expected %h", bus.q, 8'h00);
        end
        tick();
        vectors++;
        if (bus.q !== 8'hF0) begin
            errors++;
            $display("FAIL load: got %h expected %h", bus.q, 8'hF0);
        end
        $display("load F0 -> o_data=%h", bus.q);
    endtask

    task automatic test_hold();
        logic [7:0] pats [3];
        pats[0] = 8'h03; pats[1] = 8'hFF; pats[2] = 8'h00;
        bus.we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.data = pats[i];
            tick();
            vectors++;
            if (bus.q !== 8'hF0) begin
                errors++;
                $display("FAIL hold[%0d]: got %h expected %h", i, bus.q, 8'hF0);
            end
            $display("hold data=%h -> o_data=%h", pats[i], bus.q);
        end
    endtask

    task automatic test_clear();
        srst = 1'b1; bus.we = 1'b0; bus.data = 8'h03;
        tick();
        vectors++;
        if (bus.q !== 8'h00) begin
            errors++;
            $display("FAIL clear: got %h expected %h", bus.q, 8'h00);
        end
        $display("clear -> o_data=%h", bus.q);
        srst = 1'b0;
        tick();
        vectors++;
        if (bus.q !== 8'h00) begin
            errors++;
            $display("FAIL clear_idle: got %h expected %h", bus.q, 8'h00);
        end
        $display("idle after clear -> o_data=%h", bus.q);
    endtask

    task automatic test_back_to_back();
        srst = 1'b0; bus.we = 1'b1; bus.data = 8'hA5;
        tick();
        vectors++;
        if (bus.q !== 8'hA5) begin
            errors++;
            $display("FAIL b2b_first: got %h expected %h", bus.q, 8'hA5);
        end
        $display("write A5 -> o_data=%h", bus.q);
        bus.data = 8'h5A;
        tick();
        vectors++;
        if (bus.q !== 8'h5A) begin
            errors++;
            $display("FAIL b2b_second: got %h expected %h", bus.q, 8'h5A);
        end
        $display("write 5A -> o_data=%h", bus.q);
        tick();
        vectors++;
        if (bus.q !== 8'h5A) begin
            errors++;
            $display("FAIL same_value: got %h expected %h", bus.q, 8'h5A);
        end
        $display("rewrite 5A -> o_data=%h", bus.q);
    endtask

    task automatic test_reset_priority();
        srst = 1'b1; bus.we = 1'b1; bus.data = 8'hFF;
        tick();
        vectors++;
        if (bus.q !== 8'h00) begin
            errors++;
            $display("FAIL reset_priority: got %h expected %h", bus.q, 8'h00);
        end
        $display("reset+we data=FF -> o_data=%h", bus.q);
    endtask

    task automatic test_mid_cycle_reset();
        srst = 1'b0; bus.we = 1'b1; bus.data = 8'h3C;
        tick();
        vectors++;
        if (bus.q !== 8'h3C) begin
            errors++;
            $display("FAIL pre_load: got %h expected %h", bus.q, 8'h3C);
        end
        bus.we = 1'b0;
        srst = 1'b1;
        #2;
        vectors++;
        if (bus.q !== 8'h3C) begin
            errors++;
            $display("FAIL reset_between_edges: got %h expected %h", bus.q, 8'h3C);
        end
        tick();
        vectors++;
        if (bus.q !== 8'h00) begin
            errors++;
            $display("FAIL reset_at_edge: got %h expected %h", bus.q, 8'h00);
        end
        $display("reset between edges -> o_data=%h after edge", bus.q);
    endtask

    task automatic test_x_recovery();
        srst = 1'b0; bus.we = 1'b1; bus.data = 'x;
        tick();
        srst = 1'b1; bus.we = 1'b0; bus.data = 8'h00;
        tick();
        vectors++;
        if (bus.q !== 8'h00) begin
            errors++;
            $display("FAIL x_recovery: got %h expected %h", bus.q, 8'h00);
        end
        $display("reset after X write -> o_data=%h", bus.q);
        srst = 1'b0; bus.we = 1'b1; bus.data = 8'h81;
        tick();
        vectors++;
        if (bus.q !== 8'h81) begin
            errors++;
            $display("FAIL post_recovery_load: got %h expected %h", bus.q, 8'h81);
        end
        $display("load 81 -> o_data=%h", bus.q);
        bus.we = 1'b0;
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        srst     = 1'b1;
        bus.we   = 1'b0;
        bus.data = '0;
        test_reset();
        test_load();
        test_hold();
        test_clear();
        test_back_to_back();
        test_reset_priority();
        test_mid_cycle_reset();
        test_x_recovery();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_reg_8bit
